// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and registered status outputs.
// Optional feature: define SYNC_FIFO_ERR_FLAGS_EN to build the sticky
// overflow/underflow flags (cleared by err_clr). Without it both flags
// are tied low and err_clr is ignored.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 9,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  rempty,
    output logic                  wfull,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Count-width constants so every comparison is width-matched.
    localparam logic [ADDR_WIDTH:0] C_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] C_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] C_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

    // Storage and state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_read;
    logic                  r_rempty;
    logic                  r_wfull;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Accept decisions use the registered flags only, so a write is never
    // accepted while full even if a read frees a slot on the same edge.
    assign w_wr_acc = write_enable & ~r_wfull;
    assign w_rd_acc = read_enable & ~r_rempty;

    // Next occupancy: +1 write-only, -1 read-only, otherwise unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Memory array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_write;
        end
    end

    // Pointers, count, read data and status flags (flags track post-edge count).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= C_ZERO;
            r_rptr      <= C_ZERO;
            r_count     <= C_ZERO;
            r_data_read <= {DATA_WIDTH{1'b0}};
            r_rempty    <= 1'b1;
            r_wfull     <= 1'b0;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rd_acc) begin
                r_rptr      <= r_rptr + C_ONE;
                r_data_read <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
            end
            r_count  <= w_count_nxt;
            r_rempty <= (w_count_nxt == C_ZERO);
            r_wfull  <= (w_count_nxt == C_DEPTH);
            r_afull  <= (w_count_nxt >= C_AFULL);
            r_aempty <= (w_count_nxt <= C_AEMPTY);
        end
    end

    assign data_read    = r_data_read;
    assign rempty       = r_rempty;
    assign wfull        = r_wfull;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign fill_count   = r_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a new error event wins over err_clr on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enable && r_wfull) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            if (read_enable && r_rempty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // err_clr has no function in this build.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed boundary scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW    = 9;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_write = '0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_read;
    logic          rempty;
    logic          wfull;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_count;
    logic          overflow;
    logic          underflow;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .data_write(data_write),
        .write_enable(write_enable), .read_enable(read_enable), .err_clr(err_clr),
        .data_read(data_read), .rempty(rempty), .wfull(wfull),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dr  = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"},  32'(fill_count), 32'(q.size()));
        check_eq({tag, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
        check_eq({tag, ".wfull"},  32'(wfull), 32'(q.size() == DEPTH));
        check_eq({tag, ".afull"},  32'(almost_full), 32'(q.size() >= AF));
        check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
        check_eq({tag, ".dread"},  32'(data_read), 32'(m_dr));
        check_eq({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
        check_eq({tag, ".udf"},    32'(underflow), 32'(m_udf));
    endtask

    // One clock cycle: drive, clock, advance model, check #1 after the edge.
    task automatic step(input string tag, input logic r, input logic we, input logic re,
                        input logic clr, input logic [DW-1:0] d);
        bit full;
        bit empty;
        rst = r; write_enable = we; read_enable = re; err_clr = clr; data_write = d;
        @(posedge clk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (r) begin
            q.delete();
            m_dr = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (we && full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (re && empty) m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
`endif
            if (re && !empty) m_dr = q.pop_front();
            if (we && !full) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    logic exp_flag;

    initial begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        exp_flag = 1'b1;
`else
        exp_flag = 1'b0;
`endif
        // Reset then idle
        step("rst", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("idle.rempty_const", 32'(rempty), 32'd1);
        check_eq("idle.dread_const", 32'(data_read), 32'd0);

        // Fill 0..15, then an extra write that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
            if (i == AF - 1) check_eq("fill.afull_at12", 32'(almost_full), 32'd1);
            if (i == AF - 2) check_eq("fill.afull_at11", 32'(almost_full), 32'd0);
        end
        check_eq("fill.wfull", 32'(wfull), 32'd1);
        step("drop", 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF);
        check_eq("drop.count", 32'(fill_count), 32'd16);
        check_eq("drop.ovf", 32'(overflow), 32'(exp_flag));

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b0, 1'b1, 1'b0, '0);
            check_eq("drain.order", 32'(data_read), 32'(i));
        end
        check_eq("drain.rempty", 32'(rempty), 32'd1);
        step("udf", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("udf.flag", 32'(underflow), 32'(exp_flag));
        for (int i = 0; i < 3; i++) step("sticky", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("sticky.ovf", 32'(overflow), 32'(exp_flag));
        check_eq("sticky.udf", 32'(underflow), 32'(exp_flag));
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_eq("clr.ovf", 32'(overflow), 32'd0);

        // Steady state at count 5 with simultaneous traffic for 40 cycles
        for (int i = 0; i < 5; i++) step("pre5", 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
        for (int i = 0; i < 40; i++) begin
            step("ss", 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
            check_eq("ss.count5", 32'(fill_count), 32'd5);
        end
        for (int i = 0; i < 5; i++) step("empty5", 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Simultaneous requests at the empty boundary
        step("simE", 1'b0, 1'b1, 1'b1, 1'b0, 9'h055);
        check_eq("simE.count1", 32'(fill_count), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) step("tofull", 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
        // Simultaneous requests at the full boundary; overflow set with err_clr
        step("simF", 1'b0, 1'b1, 1'b1, 1'b1, 9'h0CC);
        check_eq("simF.count15", 32'(fill_count), 32'd15);
        check_eq("simF.ovf_setwins", 32'(overflow), 32'(exp_flag));

        // Reset with 9 entries, then write/read 0x0AA
        while (q.size() > 9) step("to9", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step("rst9", 1'b1, 1'b1, 1'b1, 1'b0, 9'h123);
        check_eq("rst9.count0", 32'(fill_count), 32'd0);
        check_eq("rst9.rempty", 32'(rempty), 32'd1);
        step("wAA", 1'b0, 1'b1, 1'b0, 1'b0, 9'h0AA);
        step("rAA", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("rAA.data", 32'(data_read), 32'h0AA);

        // Randomized traffic with alternating bias to visit full and empty
        for (int i = 0; i < 3000; i++) begin
            int wb;
            wb = ((i / 150) % 2 == 0) ? 75 : 25;
            step("rnd",
                 ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < wb),
                 ($urandom_range(0, 99) < (100 - wb)),
                 ($urandom_range(0, 19) == 0),
                 DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
